// File: rtl/ov7670_grid_avg.sv
// ov7670_grid_avg
// Reduces every qualified OV7670 frame to a GRID_Y x GRID_X array of 8-bit
// block averages. Runs continuously: each frame is qualified by a settled
// vsync pulse, accumulated band by band, then published through a
// valid/ack holding register together with its min/max block value.
//
// Ports
//   pclk         in   pixel clock, all logic on its rising edge
//   reset        in   asynchronous, active-high
//   vsync, href  in   camera sync signals
//   d[7:0]       in   pixel byte
//   frame_ack    in   consumer has taken the published frame
//   frame        out  block (r,c) at [8*(r*GRID_X+c) +: 8], r=0 top, c=0 left
//   frame_valid  out  frame holds an unacked result
//   frame_min    out  smallest published block value
//   frame_max    out  largest published block value
//   overrun_cnt  out  saturating count of dropped or overwritten frames
module ov7670_grid_avg #(
  parameter int H_PIX         = 640,
  parameter int V_LINES       = 480,
  parameter int GRID_X        = 16,
  parameter int GRID_Y        = 16,
  parameter int BYTES_PER_PIX = 2,
  parameter int PIX_SEL       = 0,
  parameter int SHIFT         = 10,
  parameter int SETTLE        = 2000,
  parameter int HOLD          = 1
) (
  input  logic                       pclk,
  input  logic                       reset,
  input  logic                       vsync,
  input  logic                       href,
  input  logic [7:0]                 d,
  input  logic                       frame_ack,
  output logic [8*GRID_X*GRID_Y-1:0] frame,
  output logic                       frame_valid,
  output logic [7:0]                 frame_min,
  output logic [7:0]                 frame_max,
  output logic [7:0]                 overrun_cnt
);

  localparam int BW  = H_PIX / GRID_X;
  localparam int BH  = V_LINES / GRID_Y;
  localparam int NB  = GRID_X * GRID_Y;
  // Accumulator holds a full block of 255s without wrapping.
  localparam int AW  = $clog2(BW * BH * 255 + 1);
  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;
  localparam int LBW = (BH > 1) ? $clog2(BH) : 1;
  localparam int BYW = (GRID_Y > 1) ? $clog2(GRID_Y) : 1;
  // Block index must be able to reach GRID_X, which marks "past the line end".
  localparam int BXW = $clog2(GRID_X + 1);
  localparam int SCW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ARMED   = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_BAND    = 3'd4,
    ST_PUBLISH = 3'd5
  } state_t;

  // Block average: shifted sum, saturated to one byte.
  function automatic logic [7:0] sat_avg(input logic [AW-1:0] sum);
    logic [AW-1:0] shifted;
    shifted = sum >> SHIFT;
    if (shifted > AW'(255)) begin
      return 8'hFF;
    end else begin
      return shifted[7:0];
    end
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic [SCW-1:0]    settle_cnt_r;
  logic              href_d_r;
  logic              line_end_r;
  logic              phase_r;
  logic [BCW-1:0]    bcnt_r;
  logic [BXW-1:0]    blk_r;
  logic [LBW-1:0]    lib_r;
  logic [BYW-1:0]    band_r;
  logic [AW-1:0]     acc_r [GRID_X];
  logic [8*NB-1:0]   work_r;

  logic              rise_s;
  logic              fall_s;
  logic              take_s;
  logic              eff_phase_s;
  logic              phase_nx_s;
  logic [BCW-1:0]    eff_bcnt_s;
  logic [BCW-1:0]    bcnt_nx_s;
  logic [BXW-1:0]    eff_blk_s;
  logic [BXW-1:0]    blk_nx_s;
  logic              lib_last_s;
  logic              band_last_s;
  logic              ack_s;
  logic [7:0]        work_min_s;
  logic [7:0]        work_max_s;

  assign lib_last_s  = (lib_r == LBW'(BH - 1));
  assign band_last_s = (band_r == BYW'(GRID_Y - 1));
  assign ack_s       = frame_ack & frame_valid;

  // Pixel position bookkeeping: a rising href restarts phase and column so
  // the first byte of the line is already treated as byte 0 of pixel 0.
  always_comb begin
    rise_s = href & ~href_d_r;
    fall_s = ~href & href_d_r;
    if (rise_s) begin
      eff_phase_s = 1'b0;
      eff_bcnt_s  = '0;
      eff_blk_s   = '0;
    end else begin
      eff_phase_s = phase_r;
      eff_bcnt_s  = bcnt_r;
      eff_blk_s   = blk_r;
    end
    take_s     = href && (eff_phase_s == 1'(PIX_SEL)) && (eff_blk_s < BXW'(GRID_X));
    phase_nx_s = (BYTES_PER_PIX == 2) ? ~eff_phase_s : 1'b0;
    if (take_s) begin
      if (eff_bcnt_s == BCW'(BW - 1)) begin
        bcnt_nx_s = '0;
        blk_nx_s  = eff_blk_s + BXW'(1);
      end else begin
        bcnt_nx_s = eff_bcnt_s + BCW'(1);
        blk_nx_s  = eff_blk_s;
      end
    end else begin
      bcnt_nx_s = eff_bcnt_s;
      blk_nx_s  = eff_blk_s;
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (vsync) state_s = ST_SETTLE;
        else       state_s = ST_IDLE;
      end
      ST_SETTLE: begin
        if (!vsync)                                state_s = ST_IDLE;
        else if (settle_cnt_r >= SCW'(SETTLE - 1)) state_s = ST_ARMED;
        else                                       state_s = ST_SETTLE;
      end
      ST_ARMED: begin
        if (!vsync) state_s = ST_ACTIVE;
        else        state_s = ST_ARMED;
      end
      ST_ACTIVE: begin
        if (vsync)                         state_s = ST_SETTLE;
        else if (line_end_r && lib_last_s) state_s = ST_BAND;
        else                               state_s = ST_ACTIVE;
      end
      ST_BAND: begin
        if (band_last_s) state_s = ST_PUBLISH;
        else             state_s = ST_ACTIVE;
      end
      ST_PUBLISH: state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Vsync-high run length; the sampling cycle that leaves IDLE or aborts
  // ACTIVE counts as the first high cycle.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      settle_cnt_r <= '0;
    end else if (vsync && ((state_r == ST_IDLE) || (state_r == ST_ACTIVE))) begin
      settle_cnt_r <= SCW'(1);
    end else if (vsync && (state_r == ST_SETTLE)) begin
      if (settle_cnt_r != SCW'(SETTLE)) settle_cnt_r <= settle_cnt_r + SCW'(1);
    end else begin
      settle_cnt_r <= '0;
    end
  end

  // Line/band counters and per-column accumulators.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      href_d_r   <= 1'b0;
      line_end_r <= 1'b0;
      phase_r    <= 1'b0;
      bcnt_r     <= '0;
      blk_r      <= '0;
      lib_r      <= '0;
      band_r     <= '0;
      for (int c = 0; c < GRID_X; c++) acc_r[c] <= '0;
    end else begin
      href_d_r   <= href;
      line_end_r <= (state_r == ST_ACTIVE) && !vsync && fall_s;
      case (state_r)
        ST_ACTIVE: begin
          if (vsync) begin
            // Abort: discard the partial frame.
            phase_r <= 1'b0;
            bcnt_r  <= '0;
            blk_r   <= '0;
            lib_r   <= '0;
            band_r  <= '0;
            for (int c = 0; c < GRID_X; c++) acc_r[c] <= '0;
          end else begin
            if (href) begin
              phase_r <= phase_nx_s;
              bcnt_r  <= bcnt_nx_s;
              blk_r   <= blk_nx_s;
            end
            for (int c = 0; c < GRID_X; c++) begin
              if (take_s && (eff_blk_s == BXW'(c))) acc_r[c] <= acc_r[c] + AW'(d);
            end
            if (line_end_r) lib_r <= lib_last_s ? '0 : lib_r + LBW'(1);
          end
        end
        ST_BAND: begin
          for (int c = 0; c < GRID_X; c++) acc_r[c] <= '0;
          band_r <= band_last_s ? '0 : band_r + BYW'(1);
        end
        default: begin
          phase_r <= 1'b0;
          bcnt_r  <= '0;
          blk_r   <= '0;
          lib_r   <= '0;
          band_r  <= '0;
          for (int c = 0; c < GRID_X; c++) acc_r[c] <= '0;
        end
      endcase
    end
  end

  // Working frame: one row of averages is committed per completed band.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      work_r <= '0;
    end else if (state_r == ST_BAND) begin
      for (int r = 0; r < GRID_Y; r++) begin
        for (int c = 0; c < GRID_X; c++) begin
          if (band_r == BYW'(r)) work_r[8*(r*GRID_X+c) +: 8] <= sat_avg(acc_r[c]);
        end
      end
    end
  end

  // Extremes over the working frame, consumed at PUBLISH.
  always_comb begin
    work_min_s = 8'hFF;
    work_max_s = 8'h00;
    for (int i = 0; i < NB; i++) begin
      work_min_s = (work_r[8*i +: 8] < work_min_s) ? work_r[8*i +: 8] : work_min_s;
      work_max_s = (work_r[8*i +: 8] > work_max_s) ? work_r[8*i +: 8] : work_max_s;
    end
  end

  // Holding register: an ack in the PUBLISH cycle frees the slot first, so
  // the new frame lands without counting an overrun.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_min   <= 8'hFF;
      frame_max   <= 8'h00;
      overrun_cnt <= 8'h00;
    end else if (state_r == ST_PUBLISH) begin
      if (!frame_valid || ack_s || (HOLD == 0)) begin
        frame       <= work_r;
        frame_min   <= work_min_s;
        frame_max   <= work_max_s;
        frame_valid <= 1'b1;
        if (frame_valid && !ack_s && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
      end else begin
        if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end
    end else if (ack_s) begin
      frame_valid <= 1'b0;
    end
  end

endmodule
